// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit controller.
package i2s_pkg;

    localparam int DATA_W_DEF     = 16;
    localparam int SCLK_RATIO_DEF = 8;
    localparam int SLOTS          = 2 * DATA_W_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock divider and slot counter for the I2S transmitter.
// Counters sit at zero while i_run is low and wrap to zero at the end of
// each slot / frame.
module i2s_clk_gen #(
    parameter  int DATA_W     = 16,
    parameter  int SCLK_RATIO = 8,
    localparam int DIV_W      = $clog2(SCLK_RATIO),
    localparam int SLOT_W     = $clog2(2 * DATA_W)
) (
    input  logic              clk_i2s,
    input  logic              reset_n,
    input  logic              i_run,
    output logic [SLOT_W-1:0] o_slot,
    output logic              o_slot_end,
    output logic              o_frame_end,
    output logic              o_sclk
);

    logic [DIV_W-1:0]  r_div;
    logic [SLOT_W-1:0] r_slot;
    logic              r_sclk;
    logic [DIV_W-1:0]  w_div_nxt;
    logic [SLOT_W-1:0] w_slot_nxt;
    logic              w_div_last;
    logic              w_slot_last;

    assign w_div_last  = (r_div == DIV_W'(SCLK_RATIO - 1));
    assign w_slot_last = (r_slot == SLOT_W'(2 * DATA_W - 1));

    // Next divider / slot values; forced to zero whenever the stream is idle.
    always_comb begin
        w_div_nxt  = '0;
        w_slot_nxt = '0;
        if (i_run) begin
            w_div_nxt  = w_div_last ? '0 : r_div + 1'b1;
            w_slot_nxt = r_slot;
            if (w_div_last) begin
                w_slot_nxt = w_slot_last ? '0 : r_slot + 1'b1;
            end
        end
    end

    // Counter registers; sclk is registered from the next divider value so it
    // lines up with the counter phase (low half first, then high half).
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            r_div  <= '0;
            r_slot <= '0;
            r_sclk <= 1'b0;
        end else begin
            r_div  <= w_div_nxt;
            r_slot <= w_slot_nxt;
            r_sclk <= i_run && (w_div_nxt >= DIV_W'(SCLK_RATIO / 2));
        end
    end

    assign o_slot      = r_slot;
    assign o_slot_end  = i_run && w_div_last;
    assign o_frame_end = o_slot_end && w_slot_last;
    assign o_sclk      = r_sclk;

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: single-entry sample buffer, shadow register,
// run/idle FSM and serial output stage.
// Build option I2S_TX_MUTE_EN: when defined, an underrun transmits silence;
// otherwise the previous sample pair is repeated.
module i2s_tx_ctrl
    import i2s_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SCLK_RATIO = SCLK_RATIO_DEF
) (
    input  logic              clk_i2s,
    input  logic              reset_n,
    input  logic              en,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              s_ready,
    output logic              tx_mclk,
    output logic              tx_sclk,
    output logic              tx_lrclk,
    output logic              tx_data,
    output logic              frame_start,
    output logic              underrun
);

    localparam int NSLOT  = 2 * DATA_W;
    localparam int SLOT_W = $clog2(NSLOT);

    state_t              r_state;
    logic                r_buf_full;
    logic [DATA_W-1:0]   r_buf_l;
    logic [DATA_W-1:0]   r_buf_r;
    logic                r_ready;
    logic [NSLOT-1:0]    r_shadow;
    logic                r_data;
    logic                r_lrclk;
    logic                r_frame_start;
    logic                r_underrun;

    logic [SLOT_W-1:0]   w_slot;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic                w_slot_end;
    logic                w_frame_end;
    logic                w_run;
    logic                w_load;
    logic                w_xfer;
    logic                w_buf_full_nxt;
    logic                w_lr_nxt;
    logic [NSLOT-1:0]    w_rot;
    logic [NSLOT-1:0]    w_shadow_nxt;

    i2s_clk_gen #(
        .DATA_W     (DATA_W),
        .SCLK_RATIO (SCLK_RATIO)
    ) u_clk_gen (
        .clk_i2s     (clk_i2s),
        .reset_n     (reset_n),
        .i_run       (w_run),
        .o_slot      (w_slot),
        .o_slot_end  (w_slot_end),
        .o_frame_end (w_frame_end),
        .o_sclk      (tx_sclk)
    );

    assign w_run          = (r_state == RUN);
    assign w_load         = en && (!w_run || w_frame_end);
    assign w_xfer         = s_valid && r_ready;
    // A load sees the buffer as it was before any same-cycle transfer.
    assign w_buf_full_nxt = (r_buf_full && !w_load) || w_xfer;
    assign w_slot_nxt     = w_slot + SLOT_W'(1);
    assign w_lr_nxt       = (w_slot_nxt >= SLOT_W'(DATA_W - 1)) &&
                            (w_slot_nxt <= SLOT_W'(NSLOT - 2));
    // The shadow rotates once per slot, so after a full frame it is back to
    // the pair that was loaded; that makes it usable for repeat-on-underrun.
    assign w_rot          = {r_shadow[NSLOT-2:0], r_shadow[NSLOT-1]};

    // Value taken by the shadow on a load.
    always_comb begin
        w_shadow_nxt = {r_buf_l, r_buf_r};
        if (!r_buf_full) begin
`ifdef I2S_TX_MUTE_EN
            w_shadow_nxt = '0;
`else
            w_shadow_nxt = w_run ? w_rot : r_shadow;
`endif
        end
    end

    // Single-entry holding buffer with registered ready.
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_buf_full <= w_buf_full_nxt;
            r_ready    <= !w_buf_full_nxt;
            if (w_xfer) begin
                r_buf_l <= s_left;
                r_buf_r <= s_right;
            end
        end
    end

    // Run/idle FSM with shadow load, serial data and word-select outputs.
    always_ff @(posedge clk_i2s or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_shadow      <= '0;
            r_data        <= 1'b0;
            r_lrclk       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            r_underrun    <= w_load && !r_buf_full;
            case (r_state)
                IDLE: begin
                    r_data  <= 1'b0;
                    r_lrclk <= 1'b0;
                    if (en) begin
                        r_state  <= RUN;
                        r_shadow <= w_shadow_nxt;
                        r_data   <= w_shadow_nxt[NSLOT-1];
                    end
                end
                RUN: begin
                    if (w_slot_end) begin
                        if (w_load) begin
                            r_shadow <= w_shadow_nxt;
                            r_data   <= w_shadow_nxt[NSLOT-1];
                            r_lrclk  <= 1'b0;
                        end else begin
                            r_shadow <= w_rot;
                            if (w_frame_end) begin
                                r_state <= IDLE;
                                r_data  <= 1'b0;
                                r_lrclk <= 1'b0;
                            end else begin
                                r_data  <= w_rot[NSLOT-1];
                                r_lrclk <= w_lr_nxt;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready     = r_ready;
    assign tx_mclk     = clk_i2s;
    assign tx_lrclk    = r_lrclk;
    assign tx_data     = r_data;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule
